// File: rtl/cp_s1_read_ram.sv
// Stage-1 RAM frame reader: issues DATA_NUM reads and streams them out through a credit-controlled FWFT FIFO.
// Optional sticky start-error flag when CP_S1_RD_START_ERR_EN is defined.
module cp_s1_read_ram #(
   parameter int RD_LATENCY     = 2,
   parameter int READ_RAM_WIDTH = 128,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_NUM       = 1024,
   parameter int INIT_ADDR      = 0,
   parameter int ADD_ADDR       = 16,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_start,
   output logic                      o_m1_rd_en,
   output logic [ADDR_WIDTH-1:0]     o_m1_rd_addr,
   input  logic [READ_RAM_WIDTH-1:0] i_m1_rd_data,
   output logic [READ_RAM_WIDTH-1:0] o_data,
   output logic                      o_data_valid,
   input  logic                      i_data_ready,
   output logic                      o_data_last,
   output logic                      o_busy,
`ifdef CP_S1_RD_START_ERR_EN
   output logic                      o_start_err,
`endif
   output logic                      o_finish
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int RC_W  = $clog2(DATA_NUM) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [RC_W-1:0]           rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]          credit_q, credit_d;
   logic [RD_LATENCY-1:0]     pipe_vld_q, pipe_vld_d;
   logic [RD_LATENCY-1:0]     pipe_last_q, pipe_last_d;
   logic [CNT_W-1:0]          wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]          rd_ptr_q, rd_ptr_d;
   logic [READ_RAM_WIDTH:0]   fifo_mem_q [FIFO_DEPTH];

   logic                      fifo_empty;
   logic                      pop;
   logic                      push;
   logic                      rd_en;
   logic                      is_last_rd;
   logic [READ_RAM_WIDTH:0]   head_word;

   // FIFO status and the credit check; credit_q = reads in flight + words buffered
   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      pop        = !fifo_empty && i_data_ready;
      push       = pipe_vld_q[RD_LATENCY-1];
      is_last_rd = (rd_cnt_q == RC_W'(DATA_NUM - 1));
      rd_en      = (state_q == S_ISSUE) &&
                   ((credit_q - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH));
      credit_d   = credit_q + CNT_W'(rd_en) - CNT_W'(pop);
      head_word  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
   end

   always_comb begin
      pipe_vld_d     = '0;
      pipe_last_d    = '0;
      pipe_vld_d[0]  = rd_en;
      pipe_last_d[0] = rd_en && is_last_rd;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_last_d[i] = pipe_last_q[i-1];
      end
      wr_ptr_d = push ? wr_ptr_q + CNT_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + CNT_W'(1) : rd_ptr_q;
   end

   // Frame sequencing: address/count reload on start, advance on every issued read
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rd_cnt_d = rd_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d  = S_ISSUE;
               addr_d   = ADDR_WIDTH'(INIT_ADDR);
               rd_cnt_d = '0;
            end
         end
         S_ISSUE: begin
            if (rd_en) begin
               addr_d   = addr_q + ADDR_WIDTH'(ADD_ADDR);
               rd_cnt_d = rd_cnt_q + RC_W'(1);
               if (is_last_rd) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (pop && head_word[READ_RAM_WIDTH]) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= ADDR_WIDTH'(INIT_ADDR);
         rd_cnt_q    <= '0;
         credit_q    <= '0;
         pipe_vld_q  <= '0;
         pipe_last_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rd_cnt_q    <= rd_cnt_d;
         credit_q    <= credit_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_last_q <= pipe_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // Storage needs no reset: pointers define validity and the output is gated when empty
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {pipe_last_q[RD_LATENCY-1], i_m1_rd_data};
      end
   end

`ifdef CP_S1_RD_START_ERR_EN
   logic start_err_q, start_err_d;

   always_comb begin
      start_err_d = start_err_q || (i_start && (state_q != S_IDLE));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_err_q <= 1'b0;
      end else begin
         start_err_q <= start_err_d;
      end
   end

   assign o_start_err = start_err_q;
`endif

   always_comb begin
      o_m1_rd_en   = rd_en;
      o_m1_rd_addr = addr_q;
      o_data_valid = !fifo_empty;
      o_data       = fifo_empty ? '0 : head_word[READ_RAM_WIDTH-1:0];
      o_data_last  = !fifo_empty && head_word[READ_RAM_WIDTH];
      o_busy       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
      o_finish     = (state_q == S_DONE);
   end

endmodule

// File: tb/tb_cp_s1_read_ram.sv
// Directed bench for cp_s1_read_ram with DATA_NUM=4, ADD_ADDR=16, RD_LATENCY=2, FIFO_DEPTH=4.
// A RAM model returns data equal to the read address two cycles after the read.
module tb_cp_s1_read_ram;

   localparam int DW = 128;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_start;
   logic          o_m1_rd_en;
   logic [AW-1:0] o_m1_rd_addr;
   logic [DW-1:0] i_m1_rd_data;
   logic [DW-1:0] o_data;
   logic          o_data_valid;
   logic          i_data_ready;
   logic          o_data_last;
   logic          o_busy;
   logic          o_finish;
`ifdef CP_S1_RD_START_ERR_EN
   logic          oStartErr;
`endif

   logic [AW-1:0] ramD1 = '0;
   logic [AW-1:0] ramD2 = '0;

   int vectors     = 0;
   int miscompares = 0;
   int cyc;
   int finishCnt;
   int lastFinishCyc;

   logic [31:0] gotData[$];
   logic [31:0] gotAddr[$];
   logic        gotLast[$];

   logic        sRdEn, sValid, sLast, sFinish, sBusy;
   logic [31:0] sAddr, sData;

   cp_s1_read_ram #(
      .RD_LATENCY    (2),
      .READ_RAM_WIDTH(DW),
      .ADDR_WIDTH    (AW),
      .DATA_NUM      (4),
      .INIT_ADDR     (0),
      .ADD_ADDR      (16),
      .FIFO_DEPTH    (4)
   ) dut (
`ifdef CP_S1_RD_START_ERR_EN
      .o_start_err (oStartErr),
`endif
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (i_start),
      .o_m1_rd_en  (o_m1_rd_en),
      .o_m1_rd_addr(o_m1_rd_addr),
      .i_m1_rd_data(i_m1_rd_data),
      .o_data      (o_data),
      .o_data_valid(o_data_valid),
      .i_data_ready(i_data_ready),
      .o_data_last (o_data_last),
      .o_busy      (o_busy),
      .o_finish    (o_finish)
   );

   always #5 clk = ~clk;

   // RAM model: data = address, two-cycle read latency
   always @(posedge clk) begin
      ramD1 <= o_m1_rd_addr;
      ramD2 <= ramD1;
   end
   assign i_m1_rd_data = {{(DW-AW){1'b0}}, ramD2};

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic resetRecord();
      gotData.delete();
      gotAddr.delete();
      gotLast.delete();
      finishCnt     = 0;
      lastFinishCyc = -1;
      cyc           = 0;
   endtask

   // One clock cycle: drive inputs just after the edge, sample mid-cycle, log activity
   task automatic applyStimulus(input logic st, input logic rdy);
      i_start      = st;
      i_data_ready = rdy;
      #3;
      sRdEn   = o_m1_rd_en;
      sAddr   = o_m1_rd_addr;
      sValid  = o_data_valid;
      sData   = o_data[31:0];
      sLast   = o_data_last;
      sFinish = o_finish;
      sBusy   = o_busy;
      if (sRdEn) gotAddr.push_back(sAddr);
      if (sValid && rdy) begin
         gotData.push_back(sData);
         gotLast.push_back(sLast);
      end
      if (sFinish) begin
         finishCnt++;
         lastFinishCyc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic checkFrame(input string tag, input int frames);
      int n = 4 * frames;
      checkOutput({tag, "_nwords"}, gotData.size(), n);
      checkOutput({tag, "_nreads"}, gotAddr.size(), n);
      for (int i = 0; i < n; i++) begin
         logic [31:0] expV;
         expV = 32'((i % 4) * 16);
         checkOutput({tag, "_addr"}, (i < gotAddr.size()) ? gotAddr[i] : 32'hDEAD_BEEF, expV);
         checkOutput({tag, "_data"}, (i < gotData.size()) ? gotData[i] : 32'hDEAD_BEEF, expV);
         checkOutput({tag, "_last"}, (i < gotLast.size()) ? gotLast[i] : 1'bx, (i % 4) == 3);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout: got no end of run, expected $finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst_n        = 1'b0;
      i_start      = 1'b0;
      i_data_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_rden",   o_m1_rd_en,   0);
      checkOutput("rst_addr",   o_m1_rd_addr, 0);
      checkOutput("rst_valid",  o_data_valid, 0);
      checkOutput("rst_data",   o_data,       0);
      checkOutput("rst_last",   o_data_last,  0);
      checkOutput("rst_busy",   o_busy,       0);
      checkOutput("rst_finish", o_finish,     0);
`ifdef CP_S1_RD_START_ERR_EN
      checkOutput("rst_err",    oStartErr,    0);
`endif
      rst_n = 1'b1;

      // Ready held high: cycle-exact timeline
      resetRecord();
      for (int c = 0; c < 10; c++) begin
         applyStimulus(c == 0, 1'b1);
         checkOutput("s1_rden", sRdEn, (c >= 1 && c <= 4));
         if (c >= 1 && c <= 4) checkOutput("s1_addr", sAddr, (c - 1) * 16);
         checkOutput("s1_valid", sValid, (c >= 4 && c <= 7));
         if (c >= 4 && c <= 7) checkOutput("s1_data", sData, (c - 4) * 16);
         checkOutput("s1_last",   sLast,   c == 7);
         checkOutput("s1_finish", sFinish, c == 8);
         checkOutput("s1_busy",   sBusy,   (c >= 1 && c <= 7));
      end

      // Ready low until cycle 20: head word must hold, reads stop at FIFO capacity
      resetRecord();
      for (int c = 0; c < 30; c++) begin
         applyStimulus(c == 0, c >= 20);
         if (c >= 4 && c <= 19) begin
            checkOutput("s2_valid", sValid, 1);
            checkOutput("s2_hold",  sData,  0);
            checkOutput("s2_last",  sLast,  0);
         end
         if (c == 19) checkOutput("s2_reads", gotAddr.size(), 4);
      end
      checkFrame("s2", 1);
      checkOutput("s2_nfinish",  finishCnt,     1);
      checkOutput("s2_fin_cyc",  lastFinishCyc, 24);

      // Ready toggling 1,0,1,0
      resetRecord();
      for (int c = 0; c < 25; c++) begin
         applyStimulus(c == 0, (c % 2) == 0);
      end
      checkFrame("s3", 1);
      checkOutput("s3_nfinish", finishCnt,     1);
      checkOutput("s3_fin_cyc", lastFinishCyc, 11);

      // Start repeated mid-frame and in the finish cycle
      resetRecord();
      for (int c = 0; c < 14; c++) begin
         applyStimulus(c == 0 || c == 2 || c == 8, 1'b1);
`ifdef CP_S1_RD_START_ERR_EN
         if (c == 1) checkOutput("s4_err_pre",  oStartErr, 0);
         if (c == 2) checkOutput("s4_err_set",  oStartErr, 1);
`endif
      end
      checkFrame("s4", 1);
      checkOutput("s4_nfinish", finishCnt,     1);
      checkOutput("s4_fin_cyc", lastFinishCyc, 8);
`ifdef CP_S1_RD_START_ERR_EN
      checkOutput("s4_err_sticky", oStartErr, 1);
`endif

      // Reset pulse in cycle 3 aborts the frame
      resetRecord();
      for (int c = 0; c < 3; c++) begin
         applyStimulus(c == 0, 1'b1);
      end
      i_start = 1'b0;
      rst_n   = 1'b0;
      #2;
      checkOutput("s5_rden",   o_m1_rd_en,   0);
      checkOutput("s5_addr",   o_m1_rd_addr, 0);
      checkOutput("s5_valid",  o_data_valid, 0);
      checkOutput("s5_data",   o_data,       0);
      checkOutput("s5_last",   o_data_last,  0);
      checkOutput("s5_busy",   o_busy,       0);
      checkOutput("s5_finish", o_finish,     0);
`ifdef CP_S1_RD_START_ERR_EN
      checkOutput("s5_err",    oStartErr,    0);
`endif
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      resetRecord();
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b0, 1'b1);
      end
      checkOutput("s5_idle_reads",  gotAddr.size(), 0);
      checkOutput("s5_idle_words",  gotData.size(), 0);
      checkOutput("s5_idle_finish", finishCnt,      0);
      resetRecord();
      for (int c = 0; c < 10; c++) begin
         applyStimulus(c == 0, 1'b1);
      end
      checkFrame("s5", 1);
      checkOutput("s5_fin_cyc", lastFinishCyc, 8);

      // Back-to-back frames: second start in the cycle after finish
      resetRecord();
      for (int c = 0; c < 20; c++) begin
         applyStimulus(c == 0 || c == 9, 1'b1);
      end
      checkFrame("s6", 2);
      checkOutput("s6_nfinish", finishCnt,     2);
      checkOutput("s6_fin_cyc", lastFinishCyc, 17);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cp_s1_read_ram.md
Name: cp_s1_read_ram

Overview:
- Reads a frame of DATA_NUM words back out of the stage-1 RAM.
- Addresses run INIT_ADDR, INIT_ADDR+ADD_ADDR, and so on.
- Absorbs the fixed RAM read latency in a small credit-controlled output FIFO.
- Presents the words as a valid/ready stream with last and finish indications.
- Sits between the stage-1 RAM read port (m1) and the downstream stage-2 consumer.

Parameters:
- RD_LATENCY, 2: cycles from rd_en/rd_addr to i_m1_rd_data valid (fixed, ≥1).
- READ_RAM_WIDTH, 128: RAM/stream data width.
- ADDR_WIDTH, 32: RAM address width.
- DATA_NUM, 1024: words per frame (≥2).
- INIT_ADDR, 0: first read address.
- ADD_ADDR, 16: address increment per word.
- FIFO_DEPTH, 4: output buffer depth; power of 2, ≥2. FIFO_DEPTH ≥ RD_LATENCY+2 gives full throughput.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- i_start, input, 1: single-cycle frame start request.
- o_m1_rd_en, output, 1: RAM read enable.
- o_m1_rd_addr, output, ADDR_WIDTH: RAM read address.
- i_m1_rd_data, input, READ_RAM_WIDTH: RAM read data, valid RD_LATENCY cycles after rd_en.
- o_data, output, READ_RAM_WIDTH: stream data.
- o_data_valid, output, 1: stream valid.
- i_data_ready, input, 1: downstream ready.
- o_data_last, output, 1: marks word DATA_NUM-1.
- o_busy, output, 1: high from the cycle after accepted i_start until the finish cycle.
- o_finish, output, 1: single-cycle end-of-frame pulse.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, FIFO empty, in-flight pipe cleared.
  - Exception: o_m1_rd_addr resets to INIT_ADDR.
  - Reset mid-frame aborts the frame. No finish pulse. Data in flight is discarded.
- FSM states:
  - IDLE: i_start → ISSUE. i_start is ignored in every other state.
  - ISSUE: issues reads. After the read for word DATA_NUM-1 is issued → DRAIN.
  - DRAIN: waits until the word with last has been transferred → DONE.
  - DONE: o_finish=1 for this one cycle → IDLE. i_start in DONE is ignored.
- Credit rule: o_m1_rd_en=1 in ISSUE only when in-flight + FIFO occupancy < FIFO_DEPTH.
  - in-flight = reads issued whose data has not yet been written into the FIFO.
  - Occupancy counts the pop in the current cycle, so a word transferred this cycle frees its slot this cycle.
  - Guarantees the FIFO never overflows. No read is ever dropped.
- Read address and count:
  - o_m1_rd_addr holds the address of the next read.
  - It advances by ADD_ADDR (modulo 2^ADDR_WIDTH) on each cycle with rd_en=1.
  - It reloads INIT_ADDR when the frame is issued.
  - A read counter (width $clog2(DATA_NUM)+1) counts issued reads 0..DATA_NUM-1.
- Return path:
  - A shift pipe of depth RD_LATENCY carries rd_en and an is-last tag.
  - At pipe exit, i_m1_rd_data and the tag are written into the FIFO in that cycle.
- Stream:
  - First-word-fall-through. o_data_valid = FIFO not empty.
  - Transfer when o_data_valid & i_data_ready.
  - Until transfer, o_data and o_data_last are held stable.
  - o_data_valid may not be withdrawn without a transfer.
- Latency: i_start in cycle 0 → first rd_en in cycle 1 → o_data_valid first high in cycle 2+RD_LATENCY.
- Throughput: 1 word/cycle with ready held high and FIFO_DEPTH ≥ RD_LATENCY+2.
- Simultaneous FIFO write and pop in the same cycle are legal, including at full or empty.
- o_finish is asserted in the cycle after the last transfer. o_busy drops in that same cycle.

Optional Feature:
- CP_S1_RD_START_ERR_EN defined:
  - Adds output o_start_err (1 bit, reset 0).
  - It is a sticky flag, set when i_start=1 while the state is not IDLE.
  - It is cleared only by reset.
- Not defined: the port is absent and i_start outside IDLE is silently ignored.

Test Plan:
All scenarios use DATA_NUM=4, INIT_ADDR=0, ADD_ADDR=16, RD_LATENCY=2, FIFO_DEPTH=4, and a RAM model returning data=addr.
- Ready always 1, start at cycle 0 → rd_en in cycles 1-4 at addresses 0,16,32,48; valid in cycles 4-7 with data 0,16,32,48; last in cycle 7; finish in cycle 8.
- Ready 0 until cycle 20 → exactly 4 reads issued, no 5th; FIFO holds 4 words; data stable; after ready rises, 4 in-order transfers then finish.
- Ready toggling 1,0,1,0 → no lost or duplicated words; last only on data 48; finish single-cycle.
- Start repeated at cycle 2 and in the finish cycle → ignored; with CP_S1_RD_START_ERR_EN, o_start_err=1 and stays 1.
- rst_n pulsed low at cycle 3 mid-frame → all outputs 0, addr=0, no finish; a new start gives a clean frame at addresses 0..48.
- Back-to-back frames with start in the cycle after finish → second frame restarts at address 0, identical output sequence.
